// File: rtl/hsync_measure.sv
// Measures incoming horizontal timing (line length, sync width, active start/width) and reports lock.
// Optional build macro HSYNC_MEASURE_EXPECT_EN adds EXP_* parameters and a timing_match output.
module hsync_measure #(
   parameter int unsigned SYNC_POL   = 0,
   parameter int unsigned LOCK_LINES = 4,
   parameter int unsigned CNT_W      = 12
`ifdef HSYNC_MEASURE_EXPECT_EN
   ,
   parameter int unsigned EXP_TOTAL  = 800,
   parameter int unsigned EXP_SYNC   = 96,
   parameter int unsigned EXP_START  = 144,
   parameter int unsigned EXP_ACTIVE = 640
`endif
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             hsync_in,
   input  logic             de_in,
   output logic [CNT_W-1:0] line_total,
   output logic [CNT_W-1:0] sync_width,
   output logic [CNT_W-1:0] active_start,
   output logic [CNT_W-1:0] active_width,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
`ifdef HSYNC_MEASURE_EXPECT_EN
   ,
   output logic             timing_match
`endif
);

   localparam int unsigned STAB_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {SEEK, MEASURE} state_t;

   state_t state, state_nxt;
   logic hs_q, de_q, sync_act, sync_act_d, de_d;
   logic lead, trail, de_rise;
   logic [CNT_W-1:0] cnt, pos, sync_w_acc, start_acc, width_acc;
   logic trail_seen, de_seen, fresh;
   logic [STAB_W-1:0] stable_cnt, stable_nxt;
   logic capture, expire, same, lock_nxt;

   assign sync_act = (hs_q == 1'(SYNC_POL));
   assign lead     = sync_act & ~sync_act_d;
   assign trail    = ~sync_act & sync_act_d;
   assign de_rise  = de_q & ~de_d;
   // Position of the current cycle within the line, lead cycle being 0
   assign pos      = cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!nrst) state <= SEEK;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      expire    = 1'b0;
      case (state)
         SEEK: begin
            if (lead) state_nxt = MEASURE;
         end
         MEASURE: begin
            if (lead) begin
               capture = 1'b1;
            end else if (cnt == CNT_MAX) begin
               expire    = 1'b1;
               state_nxt = SEEK;
            end
         end
         default: state_nxt = SEEK;
      endcase
   end

   // Stability tracking against the previously captured line
   always_comb begin
      same = !fresh
             && (pos == line_total) && (sync_w_acc == sync_width)
             && (start_acc == active_start) && (width_acc == active_width);
      if (!same)
         stable_nxt = '0;
      else if (stable_cnt >= STAB_W'(LOCK_LINES))
         stable_nxt = stable_cnt;
      else
         stable_nxt = stable_cnt + STAB_W'(1);
      lock_nxt = (stable_nxt >= STAB_W'(LOCK_LINES))
`ifdef HSYNC_MEASURE_EXPECT_EN
                 && (pos == CNT_W'(EXP_TOTAL)) && (sync_w_acc == CNT_W'(EXP_SYNC))
                 && (start_acc == CNT_W'(EXP_START)) && (width_acc == CNT_W'(EXP_ACTIVE))
`endif
                 ;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         hs_q         <= ~1'(SYNC_POL);
         de_q         <= 1'b0;
         sync_act_d   <= 1'b0;
         de_d         <= 1'b0;
         cnt          <= '0;
         sync_w_acc   <= '0;
         start_acc    <= '0;
         width_acc    <= '0;
         trail_seen   <= 1'b0;
         de_seen      <= 1'b0;
         fresh        <= 1'b1;
         stable_cnt   <= '0;
         line_total   <= '0;
         sync_width   <= '0;
         active_start <= '0;
         active_width <= '0;
         meas_valid   <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
`ifdef HSYNC_MEASURE_EXPECT_EN
         timing_match <= 1'b0;
`endif
      end else begin
         hs_q       <= hsync_in;
         de_q       <= de_in;
         sync_act_d <= sync_act;
         de_d       <= de_q;
         meas_valid <= capture;
         timeout    <= expire;

         // A de rise or de-high in the lead cycle belongs to the new line
         if (lead) begin
            cnt        <= '0;
            trail_seen <= 1'b0;
            sync_w_acc <= '0;
            de_seen    <= de_rise;
            start_acc  <= '0;
            width_acc  <= de_q ? CNT_W'(1) : '0;
         end else if (state == MEASURE) begin
            cnt <= expire ? '0 : pos;
            if (trail && !trail_seen) begin
               trail_seen <= 1'b1;
               sync_w_acc <= pos;
            end
            if (de_rise && !de_seen) begin
               de_seen   <= 1'b1;
               start_acc <= pos;
            end
            if (de_q) width_acc <= width_acc + CNT_W'(1);
         end

         if (capture) begin
            line_total   <= pos;
            sync_width   <= sync_w_acc;
            active_start <= start_acc;
            active_width <= width_acc;
            stable_cnt   <= stable_nxt;
            locked       <= lock_nxt;
            fresh        <= 1'b0;
`ifdef HSYNC_MEASURE_EXPECT_EN
            timing_match <= (pos == CNT_W'(EXP_TOTAL)) && (sync_w_acc == CNT_W'(EXP_SYNC))
                            && (start_acc == CNT_W'(EXP_START))
                            && (width_acc == CNT_W'(EXP_ACTIVE));
`endif
         end else if (expire) begin
            locked     <= 1'b0;
            stable_cnt <= '0;
            fresh      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hsync_measure.sv
// Directed bench for hsync_measure: active-low and active-high sync instances driven from one stimulus.
module tb_hsync_measure;

   localparam int unsigned CNT_W = 12;

   logic clk = 1'b0;
   logic nrst, hs, de;
   logic [CNT_W-1:0] lt0, sw0, as0, aw0, lt1, sw1, as1, aw1;
   logic mv0, lk0, to0, mv1, lk1, to1;
`ifdef HSYNC_MEASURE_EXPECT_EN
   logic tm0, tm1;
`endif

   always #5 clk = ~clk;

   hsync_measure #(.SYNC_POL(0), .LOCK_LINES(4), .CNT_W(CNT_W)) u_neg (
      .clk(clk), .nrst(nrst), .hsync_in(hs), .de_in(de),
      .line_total(lt0), .sync_width(sw0), .active_start(as0), .active_width(aw0),
      .meas_valid(mv0), .locked(lk0), .timeout(to0)
`ifdef HSYNC_MEASURE_EXPECT_EN
      , .timing_match(tm0)
`endif
   );

   hsync_measure #(.SYNC_POL(1), .LOCK_LINES(4), .CNT_W(CNT_W)) u_pos (
      .clk(clk), .nrst(nrst), .hsync_in(~hs), .de_in(de),
      .line_total(lt1), .sync_width(sw1), .active_start(as1), .active_width(aw1),
      .meas_valid(mv1), .locked(lk1), .timeout(to1)
`ifdef HSYNC_MEASURE_EXPECT_EN
      , .timing_match(tm1)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mv_cnt0 = 0, mv_cnt1 = 0, to_cnt0 = 0, to_cnt1 = 0;
   int last_mv_cyc = 0, to_cyc = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mv0) begin
         mv_cnt0     <= mv_cnt0 + 1;
         last_mv_cyc <= cyc;
      end
      if (to0) begin
         to_cnt0 <= to_cnt0 + 1;
         to_cyc  <= cyc;
      end
      if (mv1) mv_cnt1 <= mv_cnt1 + 1;
      if (to1) to_cnt1 <= to_cnt1 + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive cycles [first,last) of one line; hs is active-low toward u_neg
   task automatic drive(input int total, input int sync, input int start, input int width,
                        input int first, input int last);
      for (int c = first; c < last; c++) begin
         @(negedge clk);
         nrst = 1'b1;
         hs   = !(c < sync);
         de   = (c >= start) && (c < start + width);
      end
   endtask

   task automatic chk_out(input string tag, input int t, input int s, input int a, input int w,
                          input int lk);
      chk({tag, "_total0"}, int'(lt0), t);
      chk({tag, "_sync0"},  int'(sw0), s);
      chk({tag, "_start0"}, int'(as0), a);
      chk({tag, "_width0"}, int'(aw0), w);
      chk({tag, "_locked0"}, int'(lk0), lk);
      chk({tag, "_total1"}, int'(lt1), t);
      chk({tag, "_sync1"},  int'(sw1), s);
      chk({tag, "_start1"}, int'(as1), a);
      chk({tag, "_width1"}, int'(aw1), w);
      chk({tag, "_locked1"}, int'(lk1), lk);
   endtask

   typedef struct {
      int total, sync, start, width;
      int mv;
      int e_total, e_sync, e_start, e_width;
      int e_locked;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(input int total, input int sync, input int start, input int width,
                               input int mv, input int et, input int es, input int ea,
                               input int ew, input int el);
      vec_t v;
      v.total = total; v.sync = sync; v.start = start; v.width = width; v.mv = mv;
      v.e_total = et; v.e_sync = es; v.e_start = ea; v.e_width = ew; v.e_locked = el;
      return v;
   endfunction

   initial begin
      int mv_base, to_base, found;

      // Row i: line shape driven, then what the capture of line i-1 must show
      tbl[0]  = mk(800, 96, 144, 640,  0,   0,  0,   0,   0, 0);
      tbl[1]  = mk(800, 96, 144, 640,  1, 800, 96, 144, 640, 0);
      tbl[2]  = mk(800, 96, 144, 640,  2, 800, 96, 144, 640, 0);
      tbl[3]  = mk(800, 96, 144, 640,  3, 800, 96, 144, 640, 0);
      tbl[4]  = mk(800, 96, 144, 640,  4, 800, 96, 144, 640, 0);
      tbl[5]  = mk(800, 96, 144, 640,  5, 800, 96, 144, 640, 1);
      tbl[6]  = mk(801, 96, 144, 640,  6, 800, 96, 144, 640, 1);
      tbl[7]  = mk(800, 96, 144, 640,  7, 801, 96, 144, 640, 0);
      tbl[8]  = mk(800, 96, 144, 640,  8, 800, 96, 144, 640, 0);
      tbl[9]  = mk(800, 96, 144, 640,  9, 800, 96, 144, 640, 0);
      tbl[10] = mk(800, 96, 144, 640, 10, 800, 96, 144, 640, 0);
      tbl[11] = mk(800, 96, 144, 640, 11, 800, 96, 144, 640, 0);
      tbl[12] = mk(800, 96, 144, 640, 12, 800, 96, 144, 640, 1);
      tbl[13] = mk(800, 96,   0,   0, 13, 800, 96, 144, 640, 1);
      tbl[14] = mk(800, 96, 144, 640, 14, 800, 96,   0,   0, 0);
      tbl[15] = mk(500, 10,  20, 100, 15, 800, 96, 144, 640, 0);
      tbl[16] = mk(800, 96, 144, 640, 16, 500, 10,  20, 100, 0);
      tbl[17] = mk(800, 96, 144, 640, 17, 800, 96, 144, 640, 0);
      tbl[18] = mk(800, 96, 144, 640, 18, 800, 96, 144, 640, 0);
      tbl[19] = mk(800, 96, 144, 640, 19, 800, 96, 144, 640, 0);
      tbl[20] = mk(800, 96, 144, 640, 20, 800, 96, 144, 640, 0);
      tbl[21] = mk(800, 96, 144, 640, 21, 800, 96, 144, 640, 1);

      nrst = 1'b0; hs = 1'b1; de = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_out("reset", 0, 0, 0, 0, 0);
      chk("reset_mv0", int'(mv0), 0);
      chk("reset_to0", int'(to0), 0);

      foreach (tbl[i]) begin
         drive(tbl[i].total, tbl[i].sync, tbl[i].start, tbl[i].width, 0, tbl[i].total);
         #1;
         chk($sformatf("v%0d_mvcnt0", i), mv_cnt0, tbl[i].mv);
         chk($sformatf("v%0d_mvcnt1", i), mv_cnt1, tbl[i].mv);
         chk_out($sformatf("v%0d", i), tbl[i].e_total, tbl[i].e_sync, tbl[i].e_start,
                 tbl[i].e_width, tbl[i].e_locked);
`ifdef HSYNC_MEASURE_EXPECT_EN
         chk($sformatf("v%0d_match0", i), int'(tm0),
             int'(tbl[i].e_total == 800 && tbl[i].e_sync == 96 &&
                  tbl[i].e_start == 144 && tbl[i].e_width == 640));
`endif
      end
      chk("table_to0", to_cnt0, 0);

      // Sync removed while locked
      to_base = to_cnt0;
      found = 0;
      for (int k = 0; k < 5000 && found == 0; k++) begin
         @(negedge clk);
         hs = 1'b1; de = 1'b0;
         #1;
         if (to_cnt0 != to_base) found = 1;
      end
      chk("timeout_seen", found, 1);
      chk("timeout_delay", to_cyc - last_mv_cyc, 4096);
      repeat (4) @(negedge clk);
      #1;
      chk("timeout_pulses0", to_cnt0 - to_base, 1);
      chk("timeout_pulses1", to_cnt1, to_cnt0);
      chk_out("after_to", 800, 96, 144, 640, 0);

      // Relock from SEEK: first line gives no capture
      mv_base = mv_cnt0;
      drive(800, 96, 144, 640, 0, 800);
      #1;
      chk("seek_first_mv", mv_cnt0 - mv_base, 0);
      drive(800, 96, 144, 640, 0, 800);
      #1;
      chk("seek_second_mv", mv_cnt0 - mv_base, 1);

      // One-cycle reset in the middle of a line
      drive(800, 96, 144, 640, 0, 400);
      @(negedge clk);
      nrst = 1'b0; hs = 1'b1; de = 1'b1;
      @(negedge clk);
      nrst = 1'b1; hs = 1'b1; de = 1'b1;
      #1;
      chk_out("midrst", 0, 0, 0, 0, 0);
      chk("midrst_mv", int'(mv0), 0);
      mv_base = mv_cnt0;
      drive(800, 96, 144, 640, 402, 800);
      drive(800, 96, 144, 640, 0, 800);
      #1;
      chk("postrst_first_mv", mv_cnt0 - mv_base, 0);
      drive(800, 96, 144, 640, 0, 800);
      #1;
      chk("postrst_second_mv", mv_cnt0 - mv_base, 1);
      chk_out("postrst", 800, 96, 144, 640, 0);

`ifdef HSYNC_MEASURE_EXPECT_EN
      // Stable but off-nominal lines never lock
      for (int k = 0; k < 6; k++) begin
         drive(799, 96, 144, 640, 0, 799);
         #1;
         if (k >= 1) begin
            chk($sformatf("exp799_%0d_match0", k), int'(tm0), 0);
            chk($sformatf("exp799_%0d_total0", k), int'(lt0), 799);
            chk($sformatf("exp799_%0d_locked0", k), int'(lk0), 0);
            chk($sformatf("exp799_%0d_locked1", k), int'(lk1), 0);
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
